// File: rtl/led_string_driver.sv
// Purpose: serialises 24-bit RGB pixels onto a single-wire LED string (GRB order, MSB first), then holds the line low to latch the frame.
// Latency: a pixel sitting in the hold register starts on the wire one edge later; back-to-back pixels follow with no gap cycles.
// Backpressure: a one-entry hold register; rgb_ready_o drops while it is full, including during the latch period.
module led_string_driver #(
    parameter int NUM_LEDS = 12,
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int T_BIT    = 62,
    parameter int T_LATCH  = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb_i,
    input  logic        rgb_valid_i,
    output logic        rgb_ready_o,
    output logic        data_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        underrun_o
);

    localparam int CW = (T_BIT > 1)    ? $clog2(T_BIT)    : 1;
    localparam int BW = $clog2(24);
    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int LW = (T_LATCH > 1)  ? $clog2(T_LATCH)  : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);
    localparam logic [BW-1:0] BIT_LAST = BW'(23);
    localparam logic [PW-1:0] PIX_LAST = PW'(NUM_LEDS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(T_LATCH - 1);
    localparam logic [LW-1:0] LAT_PRE  = LW'((T_LATCH > 1) ? T_LATCH - 2 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t        state;
    logic [23:0]   hold_rgb;
    logic          hold_valid;
    logic [23:0]   shift_reg;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] latch_cnt;

    logic accept;
    logic load;
    logic bit_end;
    logic pix_end;
    logic frame_end;
    logic lat_end;

    assign rgb_ready_o = !hold_valid;
    assign accept      = rgb_valid_i && rgb_ready_o;
    assign busy_o      = (state != IDLE);

    // Decode period boundaries and whether the hold register is consumed this edge.
    always_comb begin
        bit_end   = (cyc_cnt == CYC_LAST);
        pix_end   = bit_end && (bit_cnt == BIT_LAST);
        frame_end = pix_end && (pix_cnt == PIX_LAST);
        lat_end   = (latch_cnt == LAT_LAST);
        load      = 1'b0;
        case (state)
            IDLE:    load = hold_valid;
            SHIFT:   load = pix_end && !frame_end && hold_valid;
            WAIT:    load = hold_valid;
            LATCH:   load = lat_end && hold_valid;
            default: load = 1'b0;
        endcase
    end

    // Hold register: accept only happens when empty and load only when full, so the two never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_rgb   <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_rgb   <= rgb_i;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    // Line FSM: bit timing, pixel/frame sequencing and registered line/pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            cyc_cnt      <= '0;
            pix_cnt      <= '0;
            latch_cnt    <= '0;
            data_o       <= 1'b0;
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
            case (state)
                IDLE: begin
                    data_o <= 1'b0;
                end
                SHIFT: begin
                    if (!bit_end) begin
                        // Within a bit: line stays high until the bit's high time has elapsed.
                        cyc_cnt <= cyc_cnt + CW'(1);
                        data_o  <= (cyc_cnt + CW'(1)) < (shift_reg[23] ? T1H_C : T0H_C);
                    end else if (!pix_end) begin
                        shift_reg <= {shift_reg[22:0], 1'b0};
                        bit_cnt   <= bit_cnt + BW'(1);
                        cyc_cnt   <= '0;
                        data_o    <= 1'b1;
                    end else if (frame_end) begin
                        state        <= LATCH;
                        latch_cnt    <= '0;
                        pix_cnt      <= '0;
                        data_o       <= 1'b0;
                        frame_done_o <= (T_LATCH == 1);
                    end else begin
                        // Mid-frame pixel boundary; the frame position survives a starvation gap.
                        pix_cnt <= pix_cnt + PW'(1);
                        if (!hold_valid) begin
                            state      <= WAIT;
                            data_o     <= 1'b0;
                            underrun_o <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    data_o <= 1'b0;
                end
                LATCH: begin
                    data_o <= 1'b0;
                    if (lat_end) begin
                        if (!hold_valid) begin
                            state <= IDLE;
                        end
                    end else begin
                        latch_cnt    <= latch_cnt + LW'(1);
                        frame_done_o <= (latch_cnt == LAT_PRE);
                    end
                end
                default: begin
                    state  <= IDLE;
                    data_o <= 1'b0;
                end
            endcase
            // Starting a pixel overrides the per-state updates above; wire order is G, R, B.
            if (load) begin
                state     <= SHIFT;
                shift_reg <= {hold_rgb[15:8], hold_rgb[23:16], hold_rgb[7:0]};
                bit_cnt   <= '0;
                cyc_cnt   <= '0;
                data_o    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_string_driver.sv
// Purpose: directed self-checking bench for led_string_driver with small timing parameters.
// Latency: inputs change 1ns after posedge, outputs are traced on negedge and checked from the trace.
// Backpressure: pixel offers hold rgb_valid_i until rgb_ready_o allows the handshake, bounded by a cycle budget.
`timescale 1ns/1ps
module tb_led_string_driver;

    localparam int NUM_LEDS = 2;
    localparam int T0H      = 2;
    localparam int T1H      = 4;
    localparam int T_BIT    = 6;
    localparam int T_LATCH  = 10;
    localparam int PIX_CYC  = 24 * T_BIT;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] rgb_i;
    logic        rgb_valid_i;
    logic        rgb_ready_o;
    logic        data_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        underrun_o;

    int n_cmp = 0;
    int n_bad = 0;

    bit rec_en = 1'b0;
    bit d_q[$];
    bit fd_q[$];
    bit ur_q[$];
    bit hs_q[$];
    bit bz_q[$];
    bit rdy_q[$];

    always #5 clk = ~clk;

    led_string_driver #(
        .NUM_LEDS (NUM_LEDS),
        .T0H      (T0H),
        .T1H      (T1H),
        .T_BIT    (T_BIT),
        .T_LATCH  (T_LATCH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rgb_i        (rgb_i),
        .rgb_valid_i  (rgb_valid_i),
        .rgb_ready_o  (rgb_ready_o),
        .data_o       (data_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .underrun_o   (underrun_o)
    );

    // Trace outputs once per cycle; hs at index k means a handshake on the following posedge.
    always @(negedge clk) begin
        if (rec_en) begin
            d_q.push_back(data_o);
            fd_q.push_back(frame_done_o);
            ur_q.push_back(underrun_o);
            hs_q.push_back(rgb_valid_i && rgb_ready_o);
            bz_q.push_back(busy_o);
            rdy_q.push_back(rgb_ready_o);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_rec();
        d_q.delete(); fd_q.delete(); ur_q.delete();
        hs_q.delete(); bz_q.delete(); rdy_q.delete();
        rec_en = 1'b1;
    endtask

    task automatic do_reset();
        rgb_valid_i = 1'b0;
        rgb_i       = '0;
        rst         = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);
    endtask

    task automatic offer(input logic [23:0] px, input int budget, output int waited);
        waited      = 0;
        rgb_i       = px;
        rgb_valid_i = 1'b1;
        while (!rgb_ready_o && waited < budget) begin
            step(1);
            waited++;
        end
        step(1);
        rgb_valid_i = 1'b0;
    endtask

    function automatic int find1(input bit q[$], input int from);
        for (int i = (from < 0) ? 0 : from; i < q.size(); i++)
            if (q[i]) return i;
        return -1;
    endfunction

    function automatic int cnt(input bit q[$], input int from, input int to);
        int n = 0;
        for (int i = (from < 0) ? 0 : from; i < to && i < q.size(); i++)
            if (q[i]) n++;
        return n;
    endfunction

    // Number of bit periods starting at s whose traced shape differs from the expected GRB waveform.
    function automatic int pixel_errs(input int s, input logic [23:0] px);
        logic [23:0] w;
        int errs;
        int h;
        errs = 0;
        w = {px[15:8], px[23:16], px[7:0]};
        if (s < 0 || s + PIX_CYC > d_q.size()) return 24;
        for (int b = 0; b < 24; b++) begin
            h = w[23-b] ? T1H : T0H;
            for (int c = 0; c < T_BIT; c++) begin
                if (d_q[s + b*T_BIT + c] !== (c < h)) begin
                    errs++;
                    break;
                end
            end
        end
        return errs;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rgb_i       = 24'($urandom());
            rgb_valid_i = 1'($urandom_range(0, 1));
            step(1);
            n_cmp++;
            if ({data_o, rgb_ready_o, busy_o, frame_done_o, underrun_o} !== 5'b01000) begin
                n_bad++;
                $display("FAIL reset_outputs cyc %0d: got {data,rdy,busy,fd,ur}=%b want 01000", i,
                         {data_o, rgb_ready_o, busy_o, frame_done_o, underrun_o});
            end
        end
        rgb_valid_i = 1'b0;
        rst = 1'b1;
        step(3);
        n_cmp++;
        if ({busy_o, rgb_ready_o, data_o} !== 3'b010) begin
            n_bad++;
            $display("FAIL reset_release_idle: got {busy,rdy,data}=%b want 010", {busy_o, rgb_ready_o, data_o});
        end
    endtask

    task automatic test_single_frame();
        int w1, w2, h1, s;
        do_reset();
        start_rec();
        offer(24'hFF0000, 10, w1);
        offer(24'h0000FF, 200, w2);
        step(2*PIX_CYC + T_LATCH + 20);
        rec_en = 1'b0;
        h1 = find1(hs_q, 0);
        s  = find1(d_q, 0);
        n_cmp++;
        if (s !== h1 + 2) begin n_bad++; $display("FAIL single_first_bit: got idx %0d want %0d", s, h1 + 2); end
        if (s < 0) s = 0;
        n_cmp++;
        if (cnt(hs_q, 0, hs_q.size()) !== 2) begin n_bad++; $display("FAIL single_handshakes: got %0d want 2", cnt(hs_q, 0, hs_q.size())); end
        n_cmp++;
        if (pixel_errs(s, 24'hFF0000) !== 0) begin n_bad++; $display("FAIL single_pix0_wave: got %0d bad bits want 0", pixel_errs(s, 24'hFF0000)); end
        n_cmp++;
        if (pixel_errs(s + PIX_CYC, 24'h0000FF) !== 0) begin n_bad++; $display("FAIL single_pix1_wave: got %0d bad bits want 0", pixel_errs(s + PIX_CYC, 24'h0000FF)); end
        n_cmp++;
        if (cnt(d_q, s + 2*PIX_CYC, d_q.size()) !== 0) begin n_bad++; $display("FAIL single_latch_low: got %0d high cycles want 0", cnt(d_q, s + 2*PIX_CYC, d_q.size())); end
        n_cmp++;
        if (cnt(fd_q, 0, fd_q.size()) !== 1) begin n_bad++; $display("FAIL single_fd_count: got %0d want 1", cnt(fd_q, 0, fd_q.size())); end
        n_cmp++;
        if (find1(fd_q, 0) !== s + 2*PIX_CYC + T_LATCH - 1) begin n_bad++; $display("FAIL single_fd_pos: got %0d want %0d", find1(fd_q, 0), s + 2*PIX_CYC + T_LATCH - 1); end
        n_cmp++;
        if (cnt(ur_q, 0, ur_q.size()) !== 0) begin n_bad++; $display("FAIL single_no_underrun: got %0d want 0", cnt(ur_q, 0, ur_q.size())); end
        n_cmp++;
        if ({bz_q[s + 2*PIX_CYC + T_LATCH - 1], bz_q[s + 2*PIX_CYC + T_LATCH]} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_busy_end: got %b want 10", {bz_q[s + 2*PIX_CYC + T_LATCH - 1], bz_q[s + 2*PIX_CYC + T_LATCH]});
        end
    endtask

    task automatic test_backpressure();
        int f1, f2, f3;
        do_reset();
        start_rec();
        rgb_i       = 24'h123456;
        rgb_valid_i = 1'b1;
        step(3*(2*PIX_CYC + T_LATCH) + 10);
        rgb_valid_i = 1'b0;
        rec_en = 1'b0;
        f1 = find1(fd_q, 0);
        f2 = find1(fd_q, f1 + 1);
        f3 = find1(fd_q, f2 + 1);
        n_cmp++;
        if (f2 - f1 !== 2*PIX_CYC + T_LATCH) begin n_bad++; $display("FAIL bp_frame_period1: got %0d want %0d", f2 - f1, 2*PIX_CYC + T_LATCH); end
        n_cmp++;
        if (f3 - f2 !== 2*PIX_CYC + T_LATCH) begin n_bad++; $display("FAIL bp_frame_period2: got %0d want %0d", f3 - f2, 2*PIX_CYC + T_LATCH); end
        if (f1 < 0) f1 = 0;
        if (f2 < 0) f2 = 0;
        n_cmp++;
        if (cnt(hs_q, f1 + 1, f2 + 1) !== 2) begin n_bad++; $display("FAIL bp_handshakes_per_frame: got %0d want 2", cnt(hs_q, f1 + 1, f2 + 1)); end
        n_cmp++;
        if ({rdy_q[f1], rdy_q[f1 + 1]} !== 2'b01) begin n_bad++; $display("FAIL bp_ready_full_then_free: got %b want 01", {rdy_q[f1], rdy_q[f1 + 1]}); end
        n_cmp++;
        if (cnt(ur_q, 0, ur_q.size()) !== 0) begin n_bad++; $display("FAIL bp_no_underrun: got %0d want 0", cnt(ur_q, 0, ur_q.size())); end
    endtask

    task automatic test_underrun();
        int w1, w2, h1, h2, s, s2;
        do_reset();
        start_rec();
        offer(24'h00A5C3, 10, w1);
        step(165);
        offer(24'h3C0081, 10, w2);
        step(PIX_CYC + T_LATCH + 10);
        rec_en = 1'b0;
        h1 = find1(hs_q, 0);
        h2 = find1(hs_q, h1 + 1);
        s  = find1(d_q, 0);
        if (s < 0) s = 0;
        s2 = find1(d_q, s + PIX_CYC);
        n_cmp++;
        if (pixel_errs(s, 24'h00A5C3) !== 0) begin n_bad++; $display("FAIL ur_pix0_wave: got %0d bad bits want 0", pixel_errs(s, 24'h00A5C3)); end
        n_cmp++;
        if (cnt(ur_q, 0, ur_q.size()) !== 1) begin n_bad++; $display("FAIL ur_count: got %0d want 1", cnt(ur_q, 0, ur_q.size())); end
        n_cmp++;
        if (find1(ur_q, 0) !== s + PIX_CYC) begin n_bad++; $display("FAIL ur_pos: got %0d want %0d", find1(ur_q, 0), s + PIX_CYC); end
        n_cmp++;
        if (s2 !== h2 + 2) begin n_bad++; $display("FAIL ur_restart: got idx %0d want %0d", s2, h2 + 2); end
        if (s2 < 0) s2 = s + PIX_CYC;
        n_cmp++;
        if (cnt(bz_q, s + PIX_CYC, s2) !== s2 - (s + PIX_CYC)) begin n_bad++; $display("FAIL ur_busy_in_gap: got %0d want %0d", cnt(bz_q, s + PIX_CYC, s2), s2 - (s + PIX_CYC)); end
        n_cmp++;
        if (pixel_errs(s2, 24'h3C0081) !== 0) begin n_bad++; $display("FAIL ur_pix1_wave: got %0d bad bits want 0", pixel_errs(s2, 24'h3C0081)); end
        n_cmp++;
        if (find1(fd_q, 0) !== s2 + PIX_CYC + T_LATCH - 1) begin n_bad++; $display("FAIL ur_frame_done: got %0d want %0d", find1(fd_q, 0), s2 + PIX_CYC + T_LATCH - 1); end
    endtask

    task automatic test_reset_mid_bit();
        int w, s, guard;
        do_reset();
        offer(24'hFFFFFF, 10, w);
        offer(24'hFFFFFF, 200, w);
        step(150);
        guard = 0;
        while (!data_o && guard < 2*T_BIT) begin
            step(1);
            guard++;
        end
        n_cmp++;
        if (data_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_precond: got data %b want 1", data_o); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({data_o, rgb_ready_o, busy_o, frame_done_o, underrun_o} !== 5'b01000) begin
            n_bad++;
            $display("FAIL rst_mid_async: got {data,rdy,busy,fd,ur}=%b want 01000", {data_o, rgb_ready_o, busy_o, frame_done_o, underrun_o});
        end
        step(2);
        rst = 1'b1;
        step(2);
        start_rec();
        offer(24'h0F0F0F, 10, w);
        step(PIX_CYC + 30);
        offer(24'hF0F0F0, 10, w);
        step(PIX_CYC + T_LATCH + 10);
        rec_en = 1'b0;
        s = find1(d_q, 0);
        if (s < 0) s = 0;
        n_cmp++;
        if (pixel_errs(s, 24'h0F0F0F) !== 0) begin n_bad++; $display("FAIL rst_mid_new_pix0: got %0d bad bits want 0", pixel_errs(s, 24'h0F0F0F)); end
        n_cmp++;
        if (find1(ur_q, 0) !== s + PIX_CYC) begin n_bad++; $display("FAIL rst_mid_pix0_not_last: underrun at %0d want %0d", find1(ur_q, 0), s + PIX_CYC); end
        n_cmp++;
        if (cnt(fd_q, 0, fd_q.size()) !== 1) begin n_bad++; $display("FAIL rst_mid_frame_done: got %0d want 1", cnt(fd_q, 0, fd_q.size())); end
    endtask

    task automatic test_latch_offer();
        int w, h2, h3, s, f;
        do_reset();
        start_rec();
        offer(24'h00FF00, 10, w);
        offer(24'h800001, 200, w);
        step(290);
        offer(24'hC30A5F, 10, w);
        step(PIX_CYC + 20);
        rec_en = 1'b0;
        s  = find1(d_q, 0);
        if (s < 0) s = 0;
        h2 = find1(hs_q, find1(hs_q, 0) + 1);
        h3 = find1(hs_q, h2 + 1);
        f  = find1(fd_q, 0);
        n_cmp++;
        if (w !== 0) begin n_bad++; $display("FAIL latch_accept_immediate: waited %0d want 0", w); end
        n_cmp++;
        if (!(h3 >= s + 2*PIX_CYC && h3 <= s + 2*PIX_CYC + T_LATCH - 2)) begin
            n_bad++;
            $display("FAIL latch_hs_in_latch: got idx %0d want %0d..%0d", h3, s + 2*PIX_CYC, s + 2*PIX_CYC + T_LATCH - 2);
        end
        n_cmp++;
        if (pixel_errs(s + PIX_CYC, 24'h800001) !== 0) begin n_bad++; $display("FAIL latch_pix1_wave: got %0d bad bits want 0", pixel_errs(s + PIX_CYC, 24'h800001)); end
        n_cmp++;
        if (f !== s + 2*PIX_CYC + T_LATCH - 1) begin n_bad++; $display("FAIL latch_fd_pos: got %0d want %0d", f, s + 2*PIX_CYC + T_LATCH - 1); end
        if (f < 0) f = s + 2*PIX_CYC + T_LATCH - 1;
        n_cmp++;
        if (find1(d_q, s + 2*PIX_CYC) !== f + 1) begin n_bad++; $display("FAIL latch_next_start: got idx %0d want %0d", find1(d_q, s + 2*PIX_CYC), f + 1); end
        n_cmp++;
        if (cnt(bz_q, s, f + 3) !== f + 3 - s) begin n_bad++; $display("FAIL latch_no_idle: busy %0d of %0d cycles", cnt(bz_q, s, f + 3), f + 3 - s); end
        n_cmp++;
        if (pixel_errs(f + 1, 24'hC30A5F) !== 0) begin n_bad++; $display("FAIL latch_new_pix_wave: got %0d bad bits want 0", pixel_errs(f + 1, 24'hC30A5F)); end
    endtask

    initial begin
        rst         = 1'b1;
        rgb_valid_i = 1'b0;
        rgb_i       = '0;
        #2;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_underrun();
        test_reset_mid_bit();
        test_latch_offer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_string_driver.md
LED_STRING_DRIVER -- requirements
Module: led_string_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 12, giving the number of pixels per frame.
REQ-002 SHALL have parameter T0H, default 20, giving the clk cycles data_o stays high for a 0 bit.
REQ-003 SHALL have parameter T1H, default 40, giving the clk cycles data_o stays high for a 1 bit.
REQ-004 SHALL have parameter T_BIT, default 62, giving the clk cycles per bit period; T_BIT > T1H > T0H >= 1.
REQ-005 SHALL have parameter T_LATCH, default 2500, giving the clk cycles data_o is held low after a frame.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port rgb_i, input, 24 bits: pixel as {R[7:0],G[7:0],B[7:0]}, the upstream colour-stage format.
REQ-009 SHALL have port rgb_valid_i, input, 1 bit: rgb_i holds a pixel.
REQ-010 SHALL have port rgb_ready_o, output, 1 bit: the block can accept a pixel this cycle.
REQ-011 SHALL have port data_o, output, 1 bit: LED serial line, driven directly from a flop.
REQ-012 SHALL have port busy_o, output, 1 bit: state is not IDLE.
REQ-013 SHALL have port frame_done_o, output, 1 bit: one-cycle pulse at the end of the latch period.
REQ-014 SHALL have port underrun_o, output, 1 bit: one-cycle pulse on a mid-frame pixel starvation.

Function
REQ-015 SHALL hold one pending pixel in a hold register; rgb_ready_o = !hold_valid, combinational from the flop only.
REQ-016 SHALL accept a pixel on each rising edge with rgb_valid_i && rgb_ready_o and set hold_valid.
REQ-017 SHALL have FSM states IDLE, SHIFT, WAIT and LATCH.
REQ-018 In IDLE with hold_valid: on the next edge SHALL move to SHIFT, load the shift register with {G,R,B}, clear hold_valid, set the bit count to 0 and the cycle count to 0, and set data_o to 1.
REQ-019 SHALL transmit MSB first, in the order G7..G0, R7..R0, B7..B0.
REQ-020 In each bit period of exactly T_BIT cycles, data_o SHALL be high for the first T1H cycles (bit 1) or T0H cycles (bit 0) and low for the rest.
REQ-021 After bit 24 of a pixel that is not the last in the frame: with hold_valid, SHALL load the next pixel on the same edge with no gap cycles; otherwise SHALL go to WAIT.
REQ-022 On entry to WAIT, SHALL pulse underrun_o for one cycle.
REQ-023 In WAIT, data_o SHALL be 0, and the block SHALL leave for SHIFT on the edge after hold_valid is seen, loading as in REQ-018.
REQ-024 After bit 24 of pixel NUM_LEDS, SHALL enter LATCH with data_o = 0 for exactly T_LATCH cycles.
REQ-025 The pixel counter SHALL be sized to NUM_LEDS, SHALL wrap to 0 at frame end, and SHALL NOT reset on underrun.
REQ-026 rgb_ready_o SHALL keep following REQ-015 during LATCH, so a next-frame pixel may be buffered there.
REQ-027 On the last LATCH cycle, SHALL pulse frame_done_o and go to SHIFT if hold_valid, else to IDLE.
REQ-028 A handshake and a load of the hold register on the same edge SHALL both take effect, with no pixel lost or duplicated.
REQ-029 All counters SHALL be sized with $clog2 of their parameter, with no overflow at maximum values.

Reset
REQ-030 While rst = 0, SHALL force immediately: state IDLE, data_o 0, hold_valid 0, all counters 0, busy_o 0, frame_done_o 0, underrun_o 0.
REQ-031 While rst = 0, rgb_ready_o SHALL read 1.
REQ-032 Reset mid-frame SHALL discard the frame; after release the next accepted pixel is pixel 0.

Verification (bench parameters: NUM_LEDS=2, T0H=2, T1H=4, T_BIT=6, T_LATCH=10)
REQ-033 Reset: hold rst=0 with random inputs -> data_o=0, rgb_ready_o=1, busy_o=0, both pulse outputs 0.
REQ-034 Single frame: pixels 24'hFF0000 then 24'h0000FF back-to-back -> 48 contiguous bit periods (288 cycles); pixel 1 is 8x(2 high,4 low), 8x(4,2), 8x(2,4); pixel 2 has its last 8 bits as (4,2); then 10 low cycles; frame_done_o pulses once; underrun_o never pulses.
REQ-035 Backpressure: hold rgb_valid_i=1 continuously -> rgb_ready_o deasserts while the hold register is full; exactly two handshakes occur per frame.
REQ-036 Underrun: delay pixel 2 by 20 cycles after pixel 1 ends -> one underrun_o pulse; data_o stays low for the whole gap; pixel 2 starts the edge after the handshake plus 1; the frame completes with frame_done_o.
REQ-037 Reset mid-bit while data_o=1 -> data_o falls without waiting for clk; after release, the next pixel is sent as pixel 0 of a new frame.
REQ-038 Pixel offered during LATCH -> accepted immediately; its first high cycle follows the frame_done_o pulse edge; no IDLE cycle occurs between frames.
